// File: rtl/thread_sequencer_if.sv
// thread_sequencer_if
//   Lock handshake and tile-address bundle between one thread_sequencer and
//   its port pair on sys_array_controller.
//   master : sequencer side (drives requests and tile addresses)
//   slave  : array-controller side (drives grant and finished pulses)
//   Signals:
//     load_lock_req / load_lock_res / load_finished : load-path handshake
//     comp_lock_req / comp_lock_res / comp_finished : compute-path handshake
//     B_addr                                        : B tile address (load)
//     A_addr / D_addr / C_addr                      : tile addresses (compute)
interface thread_sequencer_if #(
  parameter int BITWIDTH = 32
);
  logic                load_lock_req;
  logic                load_lock_res;
  logic                load_finished;
  logic [BITWIDTH-1:0] B_addr;
  logic                comp_lock_req;
  logic                comp_lock_res;
  logic                comp_finished;
  logic [BITWIDTH-1:0] A_addr;
  logic [BITWIDTH-1:0] D_addr;
  logic [BITWIDTH-1:0] C_addr;

  modport master (
    output load_lock_req, B_addr, comp_lock_req, A_addr, D_addr, C_addr,
    input  load_lock_res, load_finished, comp_lock_res, comp_finished
  );

  modport slave (
    input  load_lock_req, B_addr, comp_lock_req, A_addr, D_addr, C_addr,
    output load_lock_res, load_finished, comp_lock_res, comp_finished
  );
endinterface

// File: rtl/thread_sequencer.sv
// thread_sequencer
//   Per-thread instruction sequencer. While i_running is high it fetches
//   32-bit instructions from imem, decodes them, and turns every LOAD / COMP
//   into one lock request / grant / finished transaction on the array
//   controller. HALT parks the thread until i_running drops.
//   Ports:
//     clock, reset   : system clock, synchronous active-high reset
//     i_running      : thread-enable level from the loader
//     o_read_addr    : imem fetch address (tracks pc)
//     i_read_instr   : imem data, valid one cycle after o_read_addr
//     o_halted       : high while parked in HALTED
//     o_pc           : current instruction address
//     ctl            : array-controller handshake and tile addresses
//   Instruction: [31:30] opcode 00 HALT, 01 LOAD, 10 COMP, 11 NOP
//     LOAD : B = [29:0]
//     COMP : A = [29:20], D = [19:10], C = [9:0]
module thread_sequencer #(
  parameter int BITWIDTH      = 32,
  parameter int IMEM_ADDRSIZE = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_running,
  output logic [IMEM_ADDRSIZE-1:0] o_read_addr,
  input  logic [31:0]              i_read_instr,
  output logic                     o_halted,
  output logic [IMEM_ADDRSIZE-1:0] o_pc,
  thread_sequencer_if.master       ctl
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_LOAD_REQ,
    S_LOAD_WAIT,
    S_COMP_REQ,
    S_COMP_WAIT,
    S_HALTED
  } state_t;

  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_COMP = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  state_t                   r_state;
  logic [IMEM_ADDRSIZE-1:0] r_pc;
  logic [BITWIDTH-1:0]      r_b_addr;
  logic [BITWIDTH-1:0]      r_a_addr;
  logic [BITWIDTH-1:0]      r_d_addr;
  logic [BITWIDTH-1:0]      r_c_addr;

  state_t                   w_state_nxt;
  logic [IMEM_ADDRSIZE-1:0] w_pc_nxt;
  logic [IMEM_ADDRSIZE-1:0] w_pc_inc;
  logic                     w_latch_b;
  logic                     w_latch_adc;
  logic [1:0]               w_op;
  logic [BITWIDTH-1:0]      w_b_fld;
  logic [BITWIDTH-1:0]      w_a_fld;
  logic [BITWIDTH-1:0]      w_d_fld;
  logic [BITWIDTH-1:0]      w_c_fld;

  assign w_op     = i_read_instr[31:30];
  // natural overflow gives the modulo-2^IMEM_ADDRSIZE wrap
  assign w_pc_inc = r_pc + {{(IMEM_ADDRSIZE-1){1'b0}}, 1'b1};

  // zero-extended operand fields; written bitwise so BITWIDTH == 30 works
  always_comb begin
    w_b_fld        = '0;
    w_a_fld        = '0;
    w_d_fld        = '0;
    w_c_fld        = '0;
    w_b_fld[29:0]  = i_read_instr[29:0];
    w_a_fld[9:0]   = i_read_instr[29:20];
    w_d_fld[9:0]   = i_read_instr[19:10];
    w_c_fld[9:0]   = i_read_instr[9:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_b_addr <= '0;
      r_a_addr <= '0;
      r_d_addr <= '0;
      r_c_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_latch_b)   r_b_addr <= w_b_fld;
      if (w_latch_adc) begin
        r_a_addr <= w_a_fld;
        r_d_addr <= w_d_fld;
        r_c_addr <= w_c_fld;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_latch_b   = 1'b0;
    w_latch_adc = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pc_nxt = '0;
        if (i_running) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (!i_running) begin
          w_state_nxt = S_IDLE;
          w_pc_nxt    = '0;
        end else begin
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        // a dropped enable wins over whatever was fetched
        if (!i_running) begin
          w_state_nxt = S_IDLE;
          w_pc_nxt    = '0;
        end else begin
          case (w_op)
            OP_HALT: w_state_nxt = S_HALTED;
            OP_LOAD: begin
              w_latch_b   = 1'b1;
              w_state_nxt = S_LOAD_REQ;
            end
            OP_COMP: begin
              w_latch_adc = 1'b1;
              w_state_nxt = S_COMP_REQ;
            end
            OP_NOP: begin
              w_pc_nxt    = w_pc_inc;
              w_state_nxt = S_FETCH;
            end
            default: w_state_nxt = S_HALTED;
          endcase
        end
      end
      // a grant in the same cycle running drops is still taken, because the
      // controller has already committed the array to this thread
      S_LOAD_REQ: begin
        if (ctl.load_lock_res) begin
          w_state_nxt = S_LOAD_WAIT;
        end else if (!i_running) begin
          w_state_nxt = S_IDLE;
          w_pc_nxt    = '0;
        end
      end
      S_LOAD_WAIT: begin
        if (ctl.load_finished) begin
          if (i_running) begin
            w_state_nxt = S_FETCH;
            w_pc_nxt    = w_pc_inc;
          end else begin
            w_state_nxt = S_IDLE;
            w_pc_nxt    = '0;
          end
        end
      end
      S_COMP_REQ: begin
        if (ctl.comp_lock_res) begin
          w_state_nxt = S_COMP_WAIT;
        end else if (!i_running) begin
          w_state_nxt = S_IDLE;
          w_pc_nxt    = '0;
        end
      end
      S_COMP_WAIT: begin
        if (ctl.comp_finished) begin
          if (i_running) begin
            w_state_nxt = S_FETCH;
            w_pc_nxt    = w_pc_inc;
          end else begin
            w_state_nxt = S_IDLE;
            w_pc_nxt    = '0;
          end
        end
      end
      S_HALTED: begin
        if (!i_running) begin
          w_state_nxt = S_IDLE;
          w_pc_nxt    = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pc_nxt    = '0;
      end
    endcase
  end

  // requests decode straight from state: exclusive by construction
  assign ctl.load_lock_req = (r_state == S_LOAD_REQ);
  assign ctl.comp_lock_req = (r_state == S_COMP_REQ);
  assign ctl.B_addr        = r_b_addr;
  assign ctl.A_addr        = r_a_addr;
  assign ctl.D_addr        = r_d_addr;
  assign ctl.C_addr        = r_c_addr;

  assign o_halted    = (r_state == S_HALTED);
  assign o_pc        = r_pc;
  assign o_read_addr = r_pc;

endmodule

// File: tb/tb_thread_sequencer.sv
module tb_thread_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        running = 1'b0;
  logic        running2 = 1'b0;
  logic [7:0]  rd_addr, pc;
  logic [1:0]  rd_addr2, pc2;
  logic [31:0] rd_instr = '0;
  logic [31:0] rd_instr2 = '0;
  logic        halted, halted2;
  logic [31:0] imem [0:255];
  logic [31:0] imem2 [0:3];

  int n_chk = 0;
  int n_pass = 0;
  int load_cnt = 0;
  int comp_cnt = 0;

  localparam logic [31:0] HALT = 32'h0000_0000;
  localparam logic [31:0] NOP  = 32'hC000_0000;

  typedef struct {
    bit          is_comp;
    logic [31:0] b, a, d, c;
    logic [7:0]  pc;
    int          lat;
  } txn_t;

  txn_t       exp_q[$];
  logic [1:0] pc_q[$];

  thread_sequencer_if #(.BITWIDTH(32)) ctl();
  thread_sequencer_if #(.BITWIDTH(32)) ctl2();

  thread_sequencer #(.BITWIDTH(32), .IMEM_ADDRSIZE(8)) dut (
    .clock(clock), .reset(reset), .i_running(running),
    .o_read_addr(rd_addr), .i_read_instr(rd_instr),
    .o_halted(halted), .o_pc(pc), .ctl(ctl)
  );

  thread_sequencer #(.BITWIDTH(32), .IMEM_ADDRSIZE(2)) dut2 (
    .clock(clock), .reset(reset), .i_running(running2),
    .o_read_addr(rd_addr2), .i_read_instr(rd_instr2),
    .o_halted(halted2), .o_pc(pc2), .ctl(ctl2)
  );

  assign ctl2.load_lock_res = 1'b0;
  assign ctl2.load_finished = 1'b0;
  assign ctl2.comp_lock_res = 1'b0;
  assign ctl2.comp_finished = 1'b0;

  always #5 clock = ~clock;

  // imem models: registered read, data one cycle after the address
  always @(posedge clock) begin
    rd_instr  <= imem[rd_addr];
    rd_instr2 <= imem2[rd_addr2];
  end

  always @(posedge clock) begin
    if (ctl.load_lock_req) load_cnt <= load_cnt + 1;
    if (ctl.comp_lock_req) comp_cnt <= comp_cnt + 1;
  end

  function automatic logic [31:0] mk_load(input logic [29:0] b);
    return {2'b01, b};
  endfunction

  function automatic logic [31:0] mk_comp(input logic [9:0] a, input logic [9:0] d, input logic [9:0] c);
    return {2'b10, a, d, c};
  endfunction

  function automatic txn_t mk_txn(input bit c, input logic [31:0] b, input logic [31:0] a,
                                  input logic [31:0] d, input logic [31:0] cc,
                                  input logic [7:0] p, input int l);
    txn_t t;
    t.is_comp = c; t.b = b; t.a = a; t.d = d; t.c = cc; t.pc = p; t.lat = l;
    return t;
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = HALT;
  endtask

  // Acts as the array controller for one transaction: waits for a request,
  // grants on its gdel-th cycle, finishes on the fdel-th wait cycle.
  task automatic serve(input int gdel, input int fdel, output bit tmo, output txn_t obs);
    int lat = 0;
    tmo = 1'b0;
    obs = mk_txn(0, 0, 0, 0, 0, 0, 0);
    while (!ctl.load_lock_req && !ctl.comp_lock_req && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    if (lat >= 100) begin
      tmo = 1'b1;
      return;
    end
    obs = mk_txn(ctl.comp_lock_req, ctl.B_addr, ctl.A_addr, ctl.D_addr, ctl.C_addr, pc, lat);
    repeat (gdel - 1) @(negedge clock);
    if (obs.is_comp) ctl.comp_lock_res = 1'b1; else ctl.load_lock_res = 1'b1;
    @(negedge clock);
    ctl.comp_lock_res = 1'b0;
    ctl.load_lock_res = 1'b0;
    repeat (fdel - 1) @(negedge clock);
    if (obs.is_comp) ctl.comp_finished = 1'b1; else ctl.load_finished = 1'b1;
    @(negedge clock);
    ctl.comp_finished = 1'b0;
    ctl.load_finished = 1'b0;
  endtask

  task automatic wait_halted(output int n);
    n = 0;
    while (!halted && n < 100) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_chk++; if (pc !== 8'd0) $display("FAIL reset_pc got %h exp 0", pc); else n_pass++;
    n_chk++; if (rd_addr !== 8'd0) $display("FAIL reset_read_addr got %h exp 0", rd_addr); else n_pass++;
    n_chk++; if (halted !== 1'b0) $display("FAIL reset_halted got %b exp 0", halted); else n_pass++;
    n_chk++; if (ctl.load_lock_req !== 1'b0) $display("FAIL reset_load_req got %b exp 0", ctl.load_lock_req); else n_pass++;
    n_chk++; if (ctl.comp_lock_req !== 1'b0) $display("FAIL reset_comp_req got %b exp 0", ctl.comp_lock_req); else n_pass++;
    n_chk++; if (ctl.B_addr !== 32'd0) $display("FAIL reset_B got %h exp 0", ctl.B_addr); else n_pass++;
    n_chk++; if ({ctl.A_addr, ctl.D_addr, ctl.C_addr} !== 96'd0) $display("FAIL reset_ADC got %h exp 0", {ctl.A_addr, ctl.D_addr, ctl.C_addr}); else n_pass++;
    n_chk++; if (pc2 !== 2'd0) $display("FAIL reset_pc2 got %h exp 0", pc2); else n_pass++;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_load();
    bit tmo; txn_t o, e; int n; int l0, c0;
    clear_imem();
    imem[0] = mk_load(30'h5);
    exp_q.push_back(mk_txn(0, 32'h5, 0, 0, 0, 8'd0, 3));
    l0 = load_cnt; c0 = comp_cnt;
    running = 1'b1;
    serve(3, 4, tmo, o);
    n_chk++; if (tmo) $display("FAIL load_timeout no request seen"); else n_pass++;
    e = exp_q.pop_front();
    n_chk++; if (o.is_comp !== e.is_comp) $display("FAIL load_kind got %0d exp %0d", o.is_comp, e.is_comp); else n_pass++;
    n_chk++; if (o.b !== e.b) $display("FAIL load_B got %h exp %h", o.b, e.b); else n_pass++;
    n_chk++; if (o.lat !== e.lat) $display("FAIL load_req_latency got %0d exp %0d", o.lat, e.lat); else n_pass++;
    wait_halted(n);
    n_chk++; if (halted !== 1'b1) $display("FAIL load_halted got %b exp 1", halted); else n_pass++;
    n_chk++; if (pc !== 8'd1) $display("FAIL load_pc got %h exp 1", pc); else n_pass++;
    n_chk++; if (load_cnt - l0 !== 3) $display("FAIL load_req_cycles got %0d exp 3", load_cnt - l0); else n_pass++;
    n_chk++; if (comp_cnt - c0 !== 0) $display("FAIL load_comp_req_cycles got %0d exp 0", comp_cnt - c0); else n_pass++;
    running = 1'b0;
    @(negedge clock);
    n_chk++; if ({halted, pc} !== 9'd0) $display("FAIL load_release got halted=%b pc=%h exp 0/0", halted, pc); else n_pass++;
  endtask

  task automatic test_comp();
    bit tmo; txn_t o, e; int n; int l0, c0;
    clear_imem();
    imem[0] = mk_comp(10'd1, 10'd2, 10'd3);
    n_chk++; if (imem[0] !== 32'h8010_0803) $display("FAIL comp_encoding got %h exp 80100803", imem[0]); else n_pass++;
    exp_q.push_back(mk_txn(1, 32'h5, 32'd1, 32'd2, 32'd3, 8'd0, 3));
    l0 = load_cnt; c0 = comp_cnt;
    running = 1'b1;
    serve(1, 1, tmo, o);
    n_chk++; if (tmo) $display("FAIL comp_timeout no request seen"); else n_pass++;
    e = exp_q.pop_front();
    n_chk++; if (o.is_comp !== e.is_comp) $display("FAIL comp_kind got %0d exp %0d", o.is_comp, e.is_comp); else n_pass++;
    n_chk++; if ({o.a, o.d, o.c} !== {e.a, e.d, e.c}) $display("FAIL comp_ADC got %h/%h/%h exp %h/%h/%h", o.a, o.d, o.c, e.a, e.d, e.c); else n_pass++;
    n_chk++; if (o.b !== e.b) $display("FAIL comp_B_hold got %h exp %h", o.b, e.b); else n_pass++;
    wait_halted(n);
    n_chk++; if (pc !== 8'd1 || halted !== 1'b1) $display("FAIL comp_end got pc=%h halted=%b exp 1/1", pc, halted); else n_pass++;
    n_chk++; if (load_cnt - l0 !== 0) $display("FAIL comp_no_load_req got %0d exp 0", load_cnt - l0); else n_pass++;
    n_chk++; if (comp_cnt - c0 !== 1) $display("FAIL comp_req_cycles got %0d exp 1", comp_cnt - c0); else n_pass++;
    running = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_nop();
    int n;
    clear_imem();
    for (int i = 0; i < 4; i++) imem[i] = NOP;
    running = 1'b1;
    wait_halted(n);
    // FETCH entered on the 1st edge, halted on the 11th
    n_chk++; if (n !== 11) $display("FAIL nop_halt_time got %0d exp 11", n); else n_pass++;
    n_chk++; if (pc !== 8'd4) $display("FAIL nop_pc got %h exp 4", pc); else n_pass++;
    running = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_run_drop();
    int n; int l0, c0;
    clear_imem();
    imem[0] = NOP;
    imem[1] = mk_comp(10'd7, 10'd8, 10'd9);
    imem[2] = mk_load(30'h1);
    running = 1'b1;
    n = 0;
    while (!ctl.comp_lock_req && n < 50) begin @(negedge clock); n++; end
    n_chk++; if (ctl.comp_lock_req !== 1'b1) $display("FAIL drop_req got %b exp 1", ctl.comp_lock_req); else n_pass++;
    ctl.comp_lock_res = 1'b1;
    @(negedge clock);
    ctl.comp_lock_res = 1'b0;
    running = 1'b0;
    repeat (2) @(negedge clock);
    n_chk++; if ({ctl.comp_lock_req, pc} !== 9'd1) $display("FAIL drop_in_wait got req=%b pc=%h exp 0/1", ctl.comp_lock_req, pc); else n_pass++;
    ctl.comp_finished = 1'b1;
    @(negedge clock);
    ctl.comp_finished = 1'b0;
    n_chk++; if (pc !== 8'd0) $display("FAIL drop_idle_pc got %h exp 0", pc); else n_pass++;
    n_chk++; if ({ctl.A_addr, ctl.D_addr, ctl.C_addr} !== {32'd7, 32'd8, 32'd9}) $display("FAIL drop_ADC got %h/%h/%h exp 7/8/9", ctl.A_addr, ctl.D_addr, ctl.C_addr); else n_pass++;
    l0 = load_cnt; c0 = comp_cnt;
    repeat (10) @(negedge clock);
    n_chk++; if ((load_cnt - l0) + (comp_cnt - c0) !== 0 || rd_addr !== 8'd0) $display("FAIL drop_no_fetch got reqs=%0d read_addr=%h exp 0/0", (load_cnt - l0) + (comp_cnt - c0), rd_addr); else n_pass++;
  endtask

  task automatic test_req_abort();
    int n;
    clear_imem();
    imem[0] = NOP;
    imem[1] = mk_load(30'h9);
    // running drops in LOAD_REQ with no grant: abort to IDLE
    running = 1'b1;
    n = 0;
    while (!ctl.load_lock_req && n < 50) begin @(negedge clock); n++; end
    n_chk++; if (pc !== 8'd1) $display("FAIL abort_req_pc got %h exp 1", pc); else n_pass++;
    running = 1'b0;
    @(negedge clock);
    n_chk++; if ({ctl.load_lock_req, pc} !== 9'd0) $display("FAIL abort_nogrant got req=%b pc=%h exp 0/0", ctl.load_lock_req, pc); else n_pass++;
    // grant in the same cycle as the drop: still honoured
    running = 1'b1;
    n = 0;
    while (!ctl.load_lock_req && n < 50) begin @(negedge clock); n++; end
    running = 1'b0;
    ctl.load_lock_res = 1'b1;
    @(negedge clock);
    ctl.load_lock_res = 1'b0;
    n_chk++; if ({ctl.load_lock_req, pc} !== 9'd1) $display("FAIL abort_grant_wait got req=%b pc=%h exp 0/1", ctl.load_lock_req, pc); else n_pass++;
    ctl.load_finished = 1'b1;
    @(negedge clock);
    ctl.load_finished = 1'b0;
    n_chk++; if (pc !== 8'd0) $display("FAIL abort_grant_done got pc=%h exp 0", pc); else n_pass++;
  endtask

  task automatic test_spurious();
    int n; int l0;
    clear_imem();
    imem[0] = mk_load(30'h3FFF_FFFF);
    l0 = load_cnt;
    ctl.load_lock_res = 1'b1; ctl.comp_lock_res = 1'b1;
    ctl.load_finished = 1'b1; ctl.comp_finished = 1'b1;
    @(negedge clock);
    ctl.load_lock_res = 1'b0; ctl.comp_lock_res = 1'b0;
    ctl.load_finished = 1'b0; ctl.comp_finished = 1'b0;
    repeat (2) @(negedge clock);
    n_chk++; if ({halted, pc, rd_addr} !== 17'd0 || load_cnt !== l0) $display("FAIL spur_idle got halted=%b pc=%h reqs=%0d exp 0", halted, pc, load_cnt - l0); else n_pass++;
    running = 1'b1;
    n = 0;
    while (!ctl.load_lock_req && n < 50) begin @(negedge clock); n++; end
    ctl.load_finished = 1'b1; ctl.comp_finished = 1'b1; ctl.comp_lock_res = 1'b1;
    @(negedge clock);
    ctl.load_finished = 1'b0; ctl.comp_finished = 1'b0; ctl.comp_lock_res = 1'b0;
    @(negedge clock);
    n_chk++; if ({ctl.load_lock_req, ctl.comp_lock_req} !== 2'b10) $display("FAIL spur_req_held got load=%b comp=%b exp 1/0", ctl.load_lock_req, ctl.comp_lock_req); else n_pass++;
    ctl.load_lock_res = 1'b1;
    @(negedge clock);
    ctl.load_lock_res = 1'b0;
    ctl.load_finished = 1'b1;
    @(negedge clock);
    ctl.load_finished = 1'b0;
    wait_halted(n);
    n_chk++; if (ctl.B_addr !== 32'h3FFF_FFFF) $display("FAIL spur_B_max got %h exp 3fffffff", ctl.B_addr); else n_pass++;
    n_chk++; if ({halted, pc} !== 9'h101) $display("FAIL spur_end got halted=%b pc=%h exp 1/1", halted, pc); else n_pass++;
    running = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    bit tmo; txn_t o, e; int n;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    clear_imem();
    imem[0] = mk_load(30'h11);
    imem[1] = mk_comp(10'd4, 10'd5, 10'd6);
    imem[2] = mk_load(30'h22);
    imem[3] = NOP;
    imem[4] = mk_comp(10'h3FF, 10'd0, 10'h3FF);
    exp_q.push_back(mk_txn(0, 32'h11, 0, 0, 0, 8'd0, 3));
    exp_q.push_back(mk_txn(1, 32'h11, 32'd4, 32'd5, 32'd6, 8'd1, 2));
    exp_q.push_back(mk_txn(0, 32'h22, 32'd4, 32'd5, 32'd6, 8'd2, 2));
    exp_q.push_back(mk_txn(1, 32'h22, 32'h3FF, 32'd0, 32'h3FF, 8'd4, 4));
    running = 1'b1;
    while (exp_q.size() > 0) begin
      serve(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), tmo, o);
      e = exp_q.pop_front();
      n_chk++;
      if (tmo || o.is_comp !== e.is_comp || o.pc !== e.pc || o.lat !== e.lat ||
          {o.b, o.a, o.d, o.c} !== {e.b, e.a, e.d, e.c})
        $display("FAIL b2b_txn got tmo=%0d comp=%0d pc=%h lat=%0d B=%h A=%h D=%h C=%h exp comp=%0d pc=%h lat=%0d B=%h A=%h D=%h C=%h",
                 tmo, o.is_comp, o.pc, o.lat, o.b, o.a, o.d, o.c, e.is_comp, e.pc, e.lat, e.b, e.a, e.d, e.c);
      else n_pass++;
    end
    wait_halted(n);
    n_chk++; if ({halted, pc} !== 9'h105) $display("FAIL b2b_end got halted=%b pc=%h exp 1/5", halted, pc); else n_pass++;
    running = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_wrap();
    logic [1:0] prev, e;
    int n;
    for (int i = 0; i < 4; i++) imem2[i] = NOP;
    pc_q.push_back(2'd0); pc_q.push_back(2'd1); pc_q.push_back(2'd2);
    pc_q.push_back(2'd3); pc_q.push_back(2'd0);
    e = pc_q.pop_front();
    n_chk++; if (pc2 !== e) $display("FAIL wrap_pc_start got %h exp %h", pc2, e); else n_pass++;
    prev = pc2;
    running2 = 1'b1;
    n = 0;
    while (!halted2 && n < 60) begin
      @(negedge clock);
      n++;
      if (pc2 !== prev) begin
        prev = pc2;
        // the loader rewrites slot 0 once it has been consumed
        if (pc2 == 2'd1) imem2[0] = HALT;
        n_chk++;
        if (pc_q.size() == 0) $display("FAIL wrap_pc_extra got %h exp none", pc2);
        else begin
          e = pc_q.pop_front();
          if (pc2 !== e) $display("FAIL wrap_pc_seq got %h exp %h", pc2, e); else n_pass++;
        end
      end
    end
    n_chk++; if ({halted2, pc2} !== 3'b100) $display("FAIL wrap_end got halted=%b pc=%h exp 1/0", halted2, pc2); else n_pass++;
    n_chk++; if (pc_q.size() !== 0) $display("FAIL wrap_pc_missing got %0d left exp 0", pc_q.size()); else n_pass++;
    running2 = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int n;
    clear_imem();
    imem[0] = NOP;
    imem[1] = mk_load(30'h7);
    running = 1'b1;
    n = 0;
    while (!ctl.load_lock_req && n < 50) begin @(negedge clock); n++; end
    n_chk++; if ({ctl.load_lock_req, pc, ctl.B_addr} !== {1'b1, 8'd1, 32'h7}) $display("FAIL rmid_pre got req=%b pc=%h B=%h exp 1/1/7", ctl.load_lock_req, pc, ctl.B_addr); else n_pass++;
    reset = 1'b1;
    @(negedge clock);
    n_chk++; if ({ctl.load_lock_req, pc, ctl.B_addr} !== 41'd0) $display("FAIL rmid_abort got req=%b pc=%h B=%h exp 0", ctl.load_lock_req, pc, ctl.B_addr); else n_pass++;
    running = 1'b0;
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    ctl.load_lock_res = 1'b0; ctl.load_finished = 1'b0;
    ctl.comp_lock_res = 1'b0; ctl.comp_finished = 1'b0;
    clear_imem();
    for (int i = 0; i < 4; i++) imem2[i] = HALT;
    test_reset();
    test_load();
    test_comp();
    test_nop();
    test_run_drop();
    test_req_abort();
    test_spurious();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
